// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues in-order ibus requests and
// buffers up to two returned words for IF/ID. Optional macro: FETCH_BYPASS_EN.
`ifndef STALL_WIDTH
`define STALL_WIDTH 6
`endif
`ifndef STALL_PC
`define STALL_PC 0
`endif
`ifndef STALL_IF
`define STALL_IF 1
`endif

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [`STALL_WIDTH-1:0] stall_i,
  input  logic                    flush_i,
  input  logic [31:0]             flush_addr_i,
  output logic                    ibus_req_o,
  output logic [31:0]             ibus_addr_o,
  input  logic                    ibus_gnt_i,
  input  logic                    ibus_rvalid_i,
  input  logic [31:0]             ibus_rdata_i,
  output logic                    inst_valid_o,
  output logic [31:0]             inst_o,
  output logic [31:0]             inst_addr_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        en_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_addr_q [2];
  logic [31:0] buf_addr_d [2];
  logic [31:0] buf_data_q [2];
  logic [31:0] buf_data_d [2];
  logic [31:0] aq_q [2];
  logic [31:0] aq_d [2];
  logic [1:0]  buf_cnt_q, buf_cnt_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  drop_q, drop_d;

  logic       stall_pc, stall_if;
  logic       rsp_keep, bypass, head_valid, pop, push, grant;
  logic [2:0] occupancy;
  logic [1:0] aq_wr, buf_wr;

  // Datapath control. A pop this cycle frees its slot for admission, which is
  // what lets back-to-back fetches sustain one instruction per cycle.
  always_comb begin
    stall_pc = stall_i[`STALL_PC];
    stall_if = stall_i[`STALL_IF];
    rsp_keep = ibus_rvalid_i && (drop_q == 2'd0) && !flush_i;
`ifdef FETCH_BYPASS_EN
    bypass   = rsp_keep && (buf_cnt_q == 2'd0);
`else
    bypass   = 1'b0;
`endif
    head_valid = !flush_i && ((buf_cnt_q != 2'd0) || bypass);
    pop        = !flush_i && (buf_cnt_q != 2'd0) && !stall_if;
    push       = rsp_keep && !(bypass && !stall_if);
    occupancy  = {1'b0, outst_q} + {1'b0, drop_q} + {1'b0, buf_cnt_q} - {2'b00, pop};
    ibus_req_o  = en_q && !flush_i && !stall_pc && (occupancy < 3'd2);
    ibus_addr_o = pc_q;
    grant       = ibus_req_o && ibus_gnt_i;

    inst_valid_o = head_valid;
    inst_addr_o  = (bypass && (buf_cnt_q == 2'd0)) ? aq_q[0] : buf_addr_q[0];
    if (!head_valid)
      inst_o = NOP;
    else if (buf_cnt_q != 2'd0)
      inst_o = buf_data_q[0];
    else
      inst_o = ibus_rdata_i;
  end

  always_comb begin
    pc_d      = pc_q;
    buf_cnt_d = buf_cnt_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    aq_wr     = 2'd0;
    buf_wr    = 2'd0;
    for (int i = 0; i < 2; i++) begin
      buf_addr_d[i] = buf_addr_q[i];
      buf_data_d[i] = buf_data_q[i];
      aq_d[i]       = aq_q[i];
    end

    if (flush_i) begin
      // Everything still in flight becomes garbage, including a response
      // landing right now.
      pc_d      = flush_addr_i & ~32'h3;
      buf_cnt_d = 2'd0;
      outst_d   = 2'd0;
      if (ibus_rvalid_i && ((drop_q != 2'd0) || (outst_q != 2'd0)))
        drop_d = drop_q + outst_q - 2'd1;
      else
        drop_d = drop_q + outst_q;
    end else begin
      if (grant)
        pc_d = pc_q + 32'd4;
      if (ibus_rvalid_i && (drop_q != 2'd0))
        drop_d = drop_q - 2'd1;

      if (rsp_keep)
        aq_d[0] = aq_q[1];
      aq_wr = outst_q - {1'b0, rsp_keep};
      if (grant)
        aq_d[aq_wr[0]] = pc_q;
      outst_d = outst_q + {1'b0, grant} - {1'b0, rsp_keep};

      if (pop) begin
        buf_addr_d[0] = buf_addr_q[1];
        buf_data_d[0] = buf_data_q[1];
      end
      buf_wr = buf_cnt_q - {1'b0, pop};
      if (push) begin
        buf_addr_d[buf_wr[0]] = aq_q[0];
        buf_data_d[buf_wr[0]] = ibus_rdata_i;
      end
      buf_cnt_d = buf_wr + {1'b0, push};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      pc_q      <= RESET_PC;
      buf_cnt_q <= 2'd0;
      outst_q   <= 2'd0;
      drop_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_addr_q[i] <= RESET_PC;
        buf_data_q[i] <= NOP;
        aq_q[i]       <= 32'h0;
      end
    end else begin
      en_q      <= 1'b1;
      pc_q      <= pc_d;
      buf_cnt_q <= buf_cnt_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      for (int i = 0; i < 2; i++) begin
        buf_addr_q[i] <= buf_addr_d[i];
        buf_data_q[i] <= buf_data_d[i];
        aq_q[i]       <= aq_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle bench for fetch_unit: streaming, IF/PC stalls,
// flush with drops, flush under full stall, and PC wrap.
`ifndef STALL_WIDTH
`define STALL_WIDTH 6
`endif
`ifndef STALL_PC
`define STALL_PC 0
`endif
`ifndef STALL_IF
`define STALL_IF 1
`endif

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D   = 32'hDA00_0000;

  logic                    clk;
  logic                    rst_n;
  logic [`STALL_WIDTH-1:0] stall_i;
  logic                    flush_i;
  logic [31:0]             flush_addr_i;
  logic                    ibus_req_o;
  logic [31:0]             ibus_addr_o;
  logic                    ibus_gnt_i;
  logic                    ibus_rvalid_i;
  logic [31:0]             ibus_rdata_i;
  logic                    inst_valid_o;
  logic [31:0]             inst_o;
  logic [31:0]             inst_addr_o;

  logic [`STALL_WIDTH-1:0] s0, sif, spc, sall;
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .flush_addr_i (flush_addr_i),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance to next cycle.
  task automatic step(input logic [`STALL_WIDTH-1:0] st, input logic fl,
                      input logic [31:0] fa, input logic g, input logic rv,
                      input logic [31:0] rd, input logic e_req,
                      input logic [31:0] e_addr, input logic e_valid,
                      input logic [31:0] e_iaddr, input logic [31:0] e_inst);
    stall_i       = st;
    flush_i       = fl;
    flush_addr_i  = fa;
    ibus_gnt_i    = g;
    ibus_rvalid_i = rv;
    ibus_rdata_i  = rd;
    #2;
    chk("ibus_req", {31'b0, ibus_req_o}, {31'b0, e_req});
    chk("ibus_addr", ibus_addr_o, e_addr);
    chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, e_valid});
    if (e_valid) begin
      chk("inst_addr", inst_addr_o, e_iaddr);
      chk("inst", inst_o, e_inst);
    end else begin
      chk("inst_nop", inst_o, NOP);
    end
    tick();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req", {31'b0, ibus_req_o}, 32'd0);
    chk("rst_addr", ibus_addr_o, 32'h0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_inst_addr", inst_addr_o, 32'h0);
  endtask

  initial begin
    s0 = '0;
    sif = '0; sif[`STALL_IF] = 1'b1;
    spc = '0; spc[`STALL_PC] = 1'b1;
    sall = '1;
    rst_n = 1'b0;
    stall_i = '0; flush_i = 1'b0; flush_addr_i = '0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
    #2;
    chk_reset_outputs();
    tick();
    chk_reset_outputs();
    rst_n = 1'b1;
    tick();
    cyc_n = 0;

    // streaming: grant every cycle, response one cycle after grant
    step(s0, 0, 0, 1, 0, 0,        1, 32'h00, 0, 0, 0);
    step(s0, 0, 0, 1, 1, D+32'h00, 1, 32'h04, 0, 0, 0);
    step(s0, 0, 0, 1, 1, D+32'h04, 1, 32'h08, 1, 32'h00, D+32'h00);
    step(s0, 0, 0, 1, 1, D+32'h08, 1, 32'h0C, 1, 32'h04, D+32'h04);
    // IF stall for three cycles: head frozen, buffer fills, requests stop
    step(sif, 0, 0, 1, 1, D+32'h0C, 0, 32'h10, 1, 32'h08, D+32'h08);
    step(sif, 0, 0, 1, 0, 0,        0, 32'h10, 1, 32'h08, D+32'h08);
    step(sif, 0, 0, 1, 0, 0,        0, 32'h10, 1, 32'h08, D+32'h08);
    step(s0,  0, 0, 1, 0, 0,        1, 32'h10, 1, 32'h08, D+32'h08);
    step(s0,  0, 0, 1, 1, D+32'h10, 1, 32'h14, 1, 32'h0C, D+32'h0C);
    // PC stall: no requests, outstanding response still delivered
    step(spc, 0, 0, 1, 1, D+32'h14, 0, 32'h18, 1, 32'h10, D+32'h10);
    step(spc, 0, 0, 1, 0, 0,        0, 32'h18, 1, 32'h14, D+32'h14);
    step(spc, 0, 0, 1, 0, 0,        0, 32'h18, 0, 0, 0);
    step(s0,  0, 0, 1, 0, 0,        1, 32'h18, 0, 0, 0);
    step(s0,  0, 0, 1, 1, D+32'h18, 1, 32'h1C, 0, 0, 0);
    step(s0,  0, 0, 1, 0, 0,        1, 32'h20, 1, 32'h18, D+32'h18);
    // flush to 0x103 (-> 0x100) with two requests outstanding
    step(s0, 1, 32'h103, 1, 0, 0,         0, 32'h24,  0, 0, 0);
    step(s0, 0, 0,       1, 1, D+32'h1C,  0, 32'h100, 0, 0, 0);
    step(s0, 0, 0,       1, 1, D+32'h20,  1, 32'h100, 0, 0, 0);
    step(s0, 0, 0,       1, 1, D+32'h100, 1, 32'h104, 0, 0, 0);
    // flush + full stall + response in the same cycle
    step(sall, 1, 32'h200, 1, 1, D+32'h104, 0, 32'h108, 0, 0, 0);
    step(s0,   0, 0,       1, 0, 0,         1, 32'h200, 0, 0, 0);
    step(s0,   0, 0,       0, 1, D+32'h200, 1, 32'h204, 0, 0, 0);
    step(s0,   0, 0,       0, 0, 0,         1, 32'h204, 1, 32'h200, D+32'h200);
    // PC wrap at the top of the address space
    step(s0, 1, 32'hFFFF_FFFE, 0, 0, 0,            0, 32'h204,       0, 0, 0);
    step(s0, 0, 0,             1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0, 0);
    step(s0, 0, 0,             0, 1, 32'h1234_5678, 1, 32'h0000_0000, 0, 0, 0);
    step(s0, 0, 0,             0, 0, 0,            1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h1234_5678);

    // asynchronous reset mid-stream with a response pending
    step(s0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    tick();
    chk_reset_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
